// File: rtl/tmds_serializer_multi.sv
// tmds_serializer_multi: multi-lane parallel-to-serial converter.
// Emits BITS_PER_CLK bits per lane per x_clk cycle, LSB first, with all lanes
// sharing one phase counter. A one-entry holding buffer absorbs upstream
// jitter; when no word is available at a word boundary an idle symbol is sent
// and an underrun is flagged.
module tmds_serializer_multi #(
   parameter int                CHANNELS     = 3,
   parameter int                WORD_W       = 10,
   parameter int                BITS_PER_CLK = 2,
   parameter logic [WORD_W-1:0] IDLE_WORD    = WORD_W'(10'b1101010100)
) (
   input  logic                             x_clk,
   input  logic                             rst,
   input  logic                             in_valid,
   input  logic [CHANNELS*WORD_W-1:0]       in_data,
   output logic                             in_ready,
   output logic [CHANNELS*BITS_PER_CLK-1:0] out_bits,
   output logic                             word_start,
   output logic                             underrun,
   output logic                             underrun_sticky,
   input  logic                             underrun_clr
);

   localparam int SLOTS = WORD_W / BITS_PER_CLK;
   localparam int PH_W  = (SLOTS > 2) ? $clog2(SLOTS) : 1;
   localparam logic [PH_W-1:0] LAST_PH = PH_W'(SLOTS - 1);

   // A word must split into a whole number of slots, and at least two of them.
   generate
      if ((WORD_W % BITS_PER_CLK) != 0 || SLOTS < 2) begin : g_bad_params
         $error("tmds_serializer_multi: WORD_W must be a multiple of BITS_PER_CLK with at least 2 slots");
      end
   endgenerate

   logic [PH_W-1:0]            phase;
   logic                       last;
   logic [WORD_W-1:0]          sh [CHANNELS];
   logic [CHANNELS*WORD_W-1:0] hold_data;
   logic                       buf_full;
   logic                       accept;
   logic                       underrun_cond;
   logic [CHANNELS*WORD_W-1:0] load_word;

   assign last          = (phase == LAST_PH);
   assign in_ready      = !buf_full || last;
   assign accept        = in_valid && in_ready;
   assign underrun_cond = last && !buf_full && !in_valid;
   assign word_start    = (phase == '0);

   // Pick the next word: buffered word first, then bypass, then idle.
   always_comb begin
      // NOTE: give every always_comb output a value on all paths so no latch is inferred.
      load_word = {CHANNELS{IDLE_WORD}};
      if (buf_full)
         load_word = hold_data;
      else if (in_valid)
         load_word = in_data;
   end

   // Per-lane shift registers: load at the word boundary, else shift right.
   always_ff @(posedge x_clk) begin
      for (int c = 0; c < CHANNELS; c++) begin
         // NOTE: sequential state is written with non-blocking assignments only.
         if (rst)
            sh[c] <= IDLE_WORD;
         else if (last)
            sh[c] <= load_word[c*WORD_W +: WORD_W];
         else
            sh[c] <= sh[c] >> BITS_PER_CLK;
      end
   end

   // Phase counter, buffer occupancy and underrun flags.
   always_ff @(posedge x_clk) begin
      if (rst) begin
         phase           <= '0;
         buf_full        <= 1'b0;
         underrun        <= 1'b0;
         underrun_sticky <= 1'b0;
      end else begin
         phase <= last ? '0 : phase + 1'b1;
         if (last)
            buf_full <= buf_full && accept;
         else if (accept)
            buf_full <= 1'b1;
         underrun <= underrun_cond;
         if (underrun_cond)
            underrun_sticky <= 1'b1;
         else if (underrun_clr)
            underrun_sticky <= 1'b0;
      end
   end

   // Holding buffer payload: captured whenever an accepted word is not bypassed.
   always_ff @(posedge x_clk) begin
      // NOTE: payload is left out of reset; buf_full alone decides whether it is meaningful.
      if (accept && (!last || buf_full))
         hold_data <= in_data;
   end

   // Output lanes come straight from the shift register LSBs.
   generate
      for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
         assign out_bits[c*BITS_PER_CLK +: BITS_PER_CLK] = sh[c][BITS_PER_CLK-1:0];
      end
   endgenerate

endmodule

// File: tb/tb_tmds_serializer_multi.sv
// Testbench for tmds_serializer_multi: table-driven vectors for reset, bit
// order, buffering and underrun flags, then sequences for back-pressure,
// reset mid-stream and a CHANNELS=4 / BITS_PER_CLK=1 instance.
module tb_tmds_serializer_multi;

   localparam logic [29:0] WORD_A = {10'h000, 10'h3FF, 10'h2A5};
   localparam logic [29:0] WORD_B = {10'h2AA, 10'h155, 10'h0F0};

   logic        x_clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [29:0] in_data = '0;
   logic        underrun_clr = 1'b0;
   logic        in_ready;
   logic [5:0]  out_bits;
   logic        word_start, underrun, underrun_sticky;

   logic        in_valid1 = 1'b0;
   logic [39:0] in_data1 = '0;
   logic        underrun_clr1 = 1'b0;
   logic        in_ready1;
   logic [3:0]  out_bits1;
   logic        word_start1, underrun1, underrun_sticky1;

   int checks = 0;
   int failures = 0;

   always #5 x_clk = ~x_clk;

   tmds_serializer_multi dut (
      .x_clk(x_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_bits(out_bits), .word_start(word_start),
      .underrun(underrun), .underrun_sticky(underrun_sticky),
      .underrun_clr(underrun_clr)
   );

   tmds_serializer_multi #(.CHANNELS(4), .BITS_PER_CLK(1)) dut1 (
      .x_clk(x_clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
      .in_ready(in_ready1), .out_bits(out_bits1), .word_start(word_start1),
      .underrun(underrun1), .underrun_sticky(underrun_sticky1),
      .underrun_clr(underrun_clr1)
   );

   typedef struct {
      logic        v;
      logic [29:0] d;
      logic        clr;
      logic [5:0]  ob;
      logic        ws;
      logic        rdy;
      logic        ur;
      logic        st;
   } tv_t;

   tv_t vecs [26];
   logic [5:0] idle_ob [5] = '{6'b000000, 6'b010101, 6'b010101, 6'b010101, 6'b111111};
   logic [9:0] idle_w = 10'b1101010100;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic tv_t mk(input logic v, input logic [29:0] d, input logic clr,
                              input logic [5:0] ob, input logic ws, input logic rdy,
                              input logic ur, input logic st);
      tv_t t;
      t.v = v; t.d = d; t.clr = clr; t.ob = ob;
      t.ws = ws; t.rdy = rdy; t.ur = ur; t.st = st;
      return t;
   endfunction

   function automatic logic [29:0] mkdata(input int n);
      return {10'(3*n + 2), 10'(3*n + 1), 10'(3*n)};
   endfunction

   initial begin
      logic [29:0] exp_q [$];
      logic [29:0] asm_w;
      logic [29:0] exp_w;
      int cnt;
      int ph;
      int slot;

      // Cycle numbering starts at the first cycle after reset (phase 0).
      // Reset idle word, then A bypassed in the cycle-4 slot.
      vecs[0]  = mk(0, '0,     0, 6'b000000, 1, 1, 0, 0);
      vecs[1]  = mk(0, '0,     0, 6'b010101, 0, 1, 0, 0);
      vecs[2]  = mk(0, '0,     0, 6'b010101, 0, 1, 0, 0);
      vecs[3]  = mk(0, '0,     0, 6'b010101, 0, 1, 0, 0);
      vecs[4]  = mk(1, WORD_A, 0, 6'b111111, 0, 1, 0, 0);
      // Word A on the wire; B accepted into the buffer at slot 0.
      vecs[5]  = mk(1, WORD_B, 0, 6'b001101, 1, 1, 0, 0);
      vecs[6]  = mk(0, '0,     0, 6'b001101, 0, 0, 0, 0);
      vecs[7]  = mk(0, '0,     0, 6'b001110, 0, 0, 0, 0);
      vecs[8]  = mk(0, '0,     0, 6'b001110, 0, 0, 0, 0);
      vecs[9]  = mk(0, '0,     0, 6'b001110, 0, 1, 0, 0);
      // Word B from the buffer; nothing pending at its last slot.
      vecs[10] = mk(0, '0,     0, 6'b100100, 1, 1, 0, 0);
      vecs[11] = mk(0, '0,     0, 6'b100100, 0, 1, 0, 0);
      vecs[12] = mk(0, '0,     0, 6'b100111, 0, 1, 0, 0);
      vecs[13] = mk(0, '0,     0, 6'b100111, 0, 1, 0, 0);
      vecs[14] = mk(0, '0,     0, 6'b100100, 0, 1, 0, 0);
      // Substituted idle word; clear coincides with the next underrun edge.
      vecs[15] = mk(0, '0,     0, 6'b000000, 1, 1, 1, 1);
      vecs[16] = mk(0, '0,     0, 6'b010101, 0, 1, 0, 1);
      vecs[17] = mk(0, '0,     0, 6'b010101, 0, 1, 0, 1);
      vecs[18] = mk(0, '0,     0, 6'b010101, 0, 1, 0, 1);
      vecs[19] = mk(0, '0,     1, 6'b111111, 0, 1, 0, 1);
      // Second idle word; a lone clear drops the sticky flag.
      vecs[20] = mk(0, '0,     0, 6'b000000, 1, 1, 1, 1);
      vecs[21] = mk(0, '0,     1, 6'b010101, 0, 1, 0, 1);
      vecs[22] = mk(0, '0,     0, 6'b010101, 0, 1, 0, 0);
      vecs[23] = mk(0, '0,     0, 6'b010101, 0, 1, 0, 0);
      vecs[24] = mk(1, WORD_A, 0, 6'b111111, 0, 1, 0, 0);
      vecs[25] = mk(0, '0,     0, 6'b001101, 1, 1, 0, 0);

      // Reset held for three cycles.
      rst = 1'b1;
      repeat (3) @(negedge x_clk);
      #1;
      check("rst.out_bits", out_bits, 6'b000000);
      check("rst.word_start", word_start, 1'b1);
      check("rst.in_ready", in_ready, 1'b1);
      check("rst.underrun", underrun, 1'b0);
      check("rst.sticky", underrun_sticky, 1'b0);
      check("rst.p1_out_bits", out_bits1, 4'b0000);
      check("rst.p1_word_start", word_start1, 1'b1);

      // Table-driven vectors.
      for (int i = 0; i < 26; i++) begin
         @(negedge x_clk);
         rst          = 1'b0;
         in_valid     = vecs[i].v;
         in_data      = vecs[i].d;
         underrun_clr = vecs[i].clr;
         #1;
         check($sformatf("vec%0d.out_bits", i), out_bits, vecs[i].ob);
         check($sformatf("vec%0d.word_start", i), word_start, vecs[i].ws);
         check($sformatf("vec%0d.in_ready", i), in_ready, vecs[i].rdy);
         check($sformatf("vec%0d.underrun", i), underrun, vecs[i].ur);
         check($sformatf("vec%0d.sticky", i), underrun_sticky, vecs[i].st);
      end

      // Back-pressure: valid held high with an incrementing pattern from cycle 26.
      cnt = 1;
      asm_w = '0;
      for (int cyc = 26; cyc <= 54; cyc++) begin
         @(negedge x_clk);
         in_valid     = (cyc <= 45);
         in_data      = mkdata(cnt);
         underrun_clr = 1'b0;
         #1;
         ph = (cyc - 25) % 5;
         if (cyc <= 45)
            check($sformatf("bp%0d.in_ready", cyc), in_ready, (cyc == 26) || (ph == 4));
         if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            cnt++;
         end
         if (cyc >= 30) begin
            slot = (cyc - 30) % 5;
            check($sformatf("bp%0d.word_start", cyc), word_start, slot == 0);
            for (int c = 0; c < 3; c++)
               asm_w[c*10 + slot*2 +: 2] = out_bits[c*2 +: 2];
            if (slot == 4) begin
               exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
               check($sformatf("bp%0d.word", cyc), asm_w, exp_w);
            end
         end
      end
      check("bp.leftover", exp_q.size(), 0);

      // Reset mid-stream with a word sitting in the buffer.
      @(negedge x_clk);
      in_valid = 1'b1;
      in_data  = mkdata(100);
      #1;
      check("mr.in_ready", in_ready, 1'b1);
      @(negedge x_clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         @(negedge x_clk);
         rst = 1'b0;
         #1;
         check($sformatf("mr%0d.out_bits", k), out_bits, idle_ob[k % 5]);
         check($sformatf("mr%0d.word_start", k), word_start, (k % 5) == 0);
         if (k == 0) begin
            check("mr0.in_ready", in_ready, 1'b1);
            check("mr0.underrun", underrun, 1'b0);
            check("mr0.sticky", underrun_sticky, 1'b0);
         end
         if (k == 5) begin
            check("mr5.underrun", underrun, 1'b1);
            check("mr5.sticky", underrun_sticky, 1'b1);
         end
         check($sformatf("p1_%0d.out_bits", k), out_bits1, {4{idle_w[k % 10]}});
         check($sformatf("p1_%0d.word_start", k), word_start1, (k % 10) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
